// File: rtl/lsu_stage.sv
// lsu_stage: mini-rv memory stage. Loads and stores go over a req/ack data port; other ops pass through.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating their offsets.
module lsu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_result,
    input  logic [31:0] ex_mem_store_data,
    input  logic        ex_mem_load,
    input  logic        ex_mem_store,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic [4:0]  ex_mem_rd_addr,
    input  logic        ex_mem_write_en,
    output logic        lsu_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] mem_wb_result,
    output logic        mem_wb_write_en,
    output logic [4:0]  mem_wb_rd_addr,
    output logic        mem_misaligned,
    output logic [31:0] mem_fault_addr
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, next_state;

    logic       mem_op, trap, start;
    logic [1:0] size_p0, off_p0;
    logic       unsigned_p0, load_p0, write_en_p0;
    logic [4:0] rd_p0;

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] off,
                                                input logic uns, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   return {{24{b[7] & ~uns}}, b};
            2'b01:   return {{16{h[15] & ~uns}}, h};
            default: return d;
        endcase
    endfunction

    assign mem_op = ex_mem_valid & (ex_mem_load | ex_mem_store);
    assign start  = (state == IDLE) & mem_op & ~trap;

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

    assign trap = mem_op & is_misaligned(ex_mem_size, ex_mem_result[1:0]);

    // A trapped op retires immediately: one-cycle flag plus the offending address.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_misaligned <= 1'b0;
            mem_fault_addr <= '0;
        end else begin
            mem_misaligned <= (state == IDLE) && trap;
            if ((state == IDLE) && trap)
                mem_fault_addr <= ex_mem_result;
        end
    end
`else
    assign trap           = 1'b0;
    assign mem_misaligned = 1'b0;
    assign mem_fault_addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        lsu_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ACCESS;
                    lsu_stall  = 1'b1;
                end
            end
            ACCESS: begin
                if (dmem_ack) next_state = IDLE;
                else          lsu_stall  = 1'b1;
            end
        endcase
        if (rst) lsu_stall = 1'b0;
    end

    // Stage boundary: request launch in IDLE, completion/writeback in ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_be         <= '0;
            mem_wb_result   <= '0;
            mem_wb_write_en <= 1'b0;
            mem_wb_rd_addr  <= '0;
        end else if (state == IDLE) begin
            mem_wb_result   <= ex_mem_result;
            mem_wb_rd_addr  <= ex_mem_rd_addr;
            mem_wb_write_en <= ex_mem_valid & ex_mem_write_en & ~mem_op;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ex_mem_store;
                dmem_addr  <= {ex_mem_result[31:2], 2'b00};
                dmem_be    <= byte_enables(ex_mem_size, ex_mem_result[1:0]);
                dmem_wdata <= store_lanes(ex_mem_size, ex_mem_store_data);
            end
        end else begin
            mem_wb_write_en <= 1'b0;
            if (dmem_ack) begin
                dmem_req       <= 1'b0;
                mem_wb_rd_addr <= rd_p0;
                if (load_p0) begin
                    mem_wb_result   <= load_extend(size_p0, off_p0, unsigned_p0, dmem_rdata);
                    mem_wb_write_en <= write_en_p0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            size_p0     <= ex_mem_size;
            off_p0      <= ex_mem_result[1:0];
            unsigned_p0 <= ex_mem_unsigned;
            load_p0     <= ex_mem_load;
            write_en_p0 <= ex_mem_write_en;
            rd_p0       <= ex_mem_rd_addr;
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: randomized scoreboard bench for lsu_stage with a word-array memory responder.
// Honours LSU_MISALIGN_TRAP_EN in its reference model.
module tb_lsu_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_valid, ex_mem_load, ex_mem_store, ex_mem_unsigned, ex_mem_write_en;
    logic [31:0] ex_mem_result, ex_mem_store_data;
    logic [1:0]  ex_mem_size;
    logic [4:0]  ex_mem_rd_addr;
    logic        lsu_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] mem_wb_result, mem_fault_addr;
    logic        mem_wb_write_en, mem_misaligned;
    logic [4:0]  mem_wb_rd_addr;

    always #5 clk = ~clk;

    lsu_stage dut (
        .clk(clk), .rst(rst),
        .ex_mem_valid(ex_mem_valid), .ex_mem_result(ex_mem_result),
        .ex_mem_store_data(ex_mem_store_data), .ex_mem_load(ex_mem_load),
        .ex_mem_store(ex_mem_store), .ex_mem_size(ex_mem_size),
        .ex_mem_unsigned(ex_mem_unsigned), .ex_mem_rd_addr(ex_mem_rd_addr),
        .ex_mem_write_en(ex_mem_write_en), .lsu_stall(lsu_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .mem_wb_result(mem_wb_result),
        .mem_wb_write_en(mem_wb_write_en), .mem_wb_rd_addr(mem_wb_rd_addr),
        .mem_misaligned(mem_misaligned), .mem_fault_addr(mem_fault_addr)
    );

    typedef struct packed {
        logic        mis;
        logic [31:0] result;
        logic [4:0]  rd;
    } wb_t;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } rq_t;

    wb_t         wb_q[$];
    rq_t         rq_q[$];
    logic [31:0] mem [16];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          abort = 0;
    bit          noack = 0;
    bit          force_ack = 0;
    int          delay_sel = -1;
    logic        prev_req = 1'b0;
    logic [68:0] snap;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access width in bytes, naturally aligned lane inside the word.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int lane_off(input logic [31:0] a, input logic [1:0] sz);
        return int'(a[1:0]) / nbytes(sz) * nbytes(sz);
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
        return 4'(((1 << nbytes(sz)) - 1) << lane_off(a, sz));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] piece, w;
        int nb;
        nb = nbytes(sz);
        piece = (nb == 4) ? d : (d & ((32'h1 << (8 * nb)) - 1));
        w = '0;
        for (int k = 0; k < 4 / nb; k++) w = w | (piece << (8 * nb * k));
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] word, mask, v;
        int nb;
        nb = nbytes(sz);
        word = mem[a[5:2]];
        if (nb == 4) return word;
        mask = (32'h1 << (8 * nb)) - 1;
        v = (word >> (8 * lane_off(a, sz))) & mask;
        if (!uns && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // Memory responder: random or fixed ack delay, read data from the word array.
    initial begin
        int wait_n;
        bit busy;
        wait_n = 0;
        busy = 0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (noack) begin
                busy = 0;
                if (force_ack) dmem_ack = 1'b1;
            end else if (dmem_req) begin
                if (!busy) begin
                    busy = 1;
                    wait_n = (delay_sel < 0) ? $urandom_range(0, 3) : delay_sel;
                end
                if (wait_n == 0) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = mem[dmem_addr[5:2]];
                    busy = 0;
                end else begin
                    wait_n--;
                end
            end else begin
                busy = 0;
            end
        end
    end

    // Monitor: writeback and request sides, sampled on the falling edge.
    initial begin
        wb_t e;
        rq_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wb_q.size() > 0) begin
                    e = wb_q.pop_front();
                    if (e.mis) begin
                        check("trap_flag", 72'(mem_misaligned), 72'(1));
                        check("trap_fault_addr", 72'(mem_fault_addr), 72'(e.result));
                        check("trap_wb_we", 72'(mem_wb_write_en), 72'(0));
                    end else begin
                        check("wb_we", 72'(mem_wb_write_en), 72'(1));
                        check("wb_result", 72'(mem_wb_result), 72'(e.result));
                        check("wb_rd", 72'(mem_wb_rd_addr), 72'(e.rd));
                        check("wb_misaligned_clear", 72'(mem_misaligned), 72'(0));
                    end
                end else begin
                    check("wb_idle", 72'({mem_wb_write_en, mem_misaligned}), 72'(0));
                end
                if (dmem_req && !prev_req) begin
                    if (rq_q.size() == 0) begin
                        check("unexpected_req", 72'(dmem_req), 72'(0));
                    end else begin
                        r = rq_q.pop_front();
                        check("dmem_we", 72'(dmem_we), 72'(r.we));
                        check("dmem_addr", 72'(dmem_addr), 72'(r.addr));
                        check("dmem_be", 72'(dmem_be), 72'(r.be));
                        if (r.we) check("dmem_wdata", 72'(dmem_wdata), 72'(r.wdata));
                        snap = {dmem_we, dmem_addr, dmem_be, dmem_wdata};
                    end
                end else if (dmem_req) begin
                    check("dmem_stable", 72'({dmem_we, dmem_addr, dmem_be, dmem_wdata}), 72'(snap));
                end
            end
            prev_req = dmem_req;
        end
    end

    task automatic drive(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we);
        ex_mem_valid = v;
        ex_mem_load = ld;
        ex_mem_store = st;
        ex_mem_size = sz;
        ex_mem_unsigned = uns;
        ex_mem_result = res;
        ex_mem_store_data = sd;
        ex_mem_rd_addr = rd;
        ex_mem_write_en = we;
    endtask

    // Present one instruction (called just after a rising edge) and hold it until retired.
    task automatic issue(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we);
        bit  mem, trap, done;
        int  cyc;
        rq_t r;
        wb_t e;
        drive(v, ld, st, sz, uns, res, sd, rd, we);
        mem = v && (ld || st);
        trap = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = mem && ((int'(res[1:0]) % nbytes(sz)) != 0);
`endif
        if (mem && !trap) begin
            r.we = st;
            r.addr = res & ~32'h3;
            r.be = ref_be(res, sz);
            r.wdata = ref_wdata(sd, sz);
            rq_q.push_back(r);
        end
        cyc = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            check("lsu_stall", 72'(lsu_stall), 72'((cyc == 0) ? (mem && !trap) : !dmem_ack));
            done = !lsu_stall;
            @(posedge clk);
            #1;
            cyc++;
            if (!done && cyc > 30) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_timeout: still stalled after %0d cycles, required ack completion", cyc);
                abort = 1;
                return;
            end
        end
        if (trap) begin
            e.mis = 1; e.result = res; e.rd = rd;
            wb_q.push_back(e);
        end else if (v && ld && we) begin
            e.mis = 0; e.result = ref_load(res, sz, uns); e.rd = rd;
            wb_q.push_back(e);
        end else if (v && !mem && we) begin
            e.mis = 0; e.result = res; e.rd = rd;
            wb_q.push_back(e);
        end
    endtask

    initial begin
        rq_t r;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h80FF_FFFF;
        rst = 1'b1;
        drive(1, 1, 0, 2'b10, 0, 32'h10, 0, 3, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 72'(lsu_stall), 72'(0));
        check("rst_req", 72'(dmem_req), 72'(0));
        check("rst_we", 72'(dmem_we), 72'(0));
        check("rst_addr", 72'(dmem_addr), 72'(0));
        check("rst_wdata", 72'(dmem_wdata), 72'(0));
        check("rst_be", 72'(dmem_be), 72'(0));
        check("rst_wb_result", 72'(mem_wb_result), 72'(0));
        check("rst_wb_we", 72'(mem_wb_write_en), 72'(0));
        check("rst_wb_rd", 72'(mem_wb_rd_addr), 72'(0));
        check("rst_misaligned", 72'(mem_misaligned), 72'(0));
        check("rst_fault_addr", 72'(mem_fault_addr), 72'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        issue(1, 0, 0, 2'b10, 0, 32'h1234, 0, 5, 1);
        delay_sel = 1;
        issue(1, 1, 0, 2'b00, 0, 32'h103, 0, 7, 1);
        issue(1, 1, 0, 2'b00, 1, 32'h103, 0, 8, 1);
        delay_sel = 3;
        issue(1, 0, 1, 2'b01, 0, 32'h202, 32'hABCD_1234, 9, 1);
        delay_sel = 0;
        issue(1, 1, 0, 2'b10, 0, 32'h10, 0, 10, 1);
        issue(1, 0, 0, 2'b10, 0, 32'hCAFE, 0, 11, 1);
        delay_sel = 1;
        issue(1, 1, 0, 2'b10, 0, 32'h6, 0, 12, 1);
        issue(1, 1, 0, 2'b01, 0, 32'h7, 0, 13, 1);

        if (!abort) begin
            noack = 1;
            drive(1, 1, 0, 2'b10, 0, 32'h20, 0, 14, 1);
            r.we = 0; r.addr = 32'h20; r.be = 4'hF; r.wdata = '0;
            rq_q.push_back(r);
            @(negedge clk);
            check("abort_stall_start", 72'(lsu_stall), 72'(1));
            @(posedge clk);
            #1;
            @(negedge clk);
            check("abort_req_high", 72'(dmem_req), 72'(1));
            @(posedge clk);
            #1;
            rst = 1'b1;
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("abort_stall_in_rst", 72'(lsu_stall), 72'(0));
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check("abort_req_dropped", 72'(dmem_req), 72'(0));
            check("abort_stall_after", 72'(lsu_stall), 72'(0));
            force_ack = 1;
            @(negedge clk);
            check("late_ack_stall", 72'(lsu_stall), 72'(0));
            force_ack = 0;
            @(negedge clk);
            check("late_ack_req", 72'(dmem_req), 72'(0));
            check("late_ack_wb_we", 72'(mem_wb_write_en), 72'(0));
            noack = 0;
            @(posedge clk);
            #1;
        end

        delay_sel = -1;
        for (int i = 0; i < 200 && !abort; i++) begin
            int kind;
            logic [31:0] a;
            logic [1:0] sz;
            kind = $urandom_range(0, 9);
            a = $urandom;
            sz = 2'($urandom_range(0, 3));
            if (kind < 3)
                issue(1, 0, 0, sz, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom));
            else if (kind < 6)
                issue(1, 1, 0, sz, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom));
            else if (kind < 8)
                issue(1, 0, 1, sz, 0, a, $urandom, 5'($urandom), 1'($urandom));
            else
                issue(0, 1'($urandom), 0, sz, 0, a, $urandom, 5'($urandom), 1);
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wb_queue_drained", 72'(wb_q.size()), 72'(0));
        check("req_queue_drained", 72'(rq_q.size()), 72'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
